// File: rtl/header_feeder.sv
// header_feeder: holds one 80-byte block header for the SHA-256d core and
// serves 32-bit message words (header + padding block) on request. It also
// owns the nonce counter that appears in word 19.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_LOAD  | accepting header bytes; requests are latched but not served
// S_FULL  | header complete; serves a pending request
// S_SERVE | one-cycle rdy pulse with data valid, then back to S_FULL
module header_feeder (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        load_en_i,
  input  logic [7:0]  load_data_i,
  input  logic        clear_i,
  input  logic        nonce_inc_i,
  input  logic        req_i,
  input  logic [4:0]  addr_i,
  output logic [31:0] data_o,
  output logic        rdy_o,
  output logic        full_o,
  output logic [31:0] nonce_o,
  output logic        wrap_o
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_FULL  = 2'd1,
    S_SERVE = 2'd2
  } state_t;

  state_t      state_q;
  logic [6:0]  cnt_q;
  logic [31:0] words_q [19];
  logic [31:0] nonce_q;
  logic [31:0] data_q;
  logic [4:0]  addr_q;
  logic        pending_q;
  logic        d_req_q;
  logic        rdy_q;
  logic        full_q;
  logic        wrap_q;
  logic [31:0] word_d;

  // Word selection for the latched address: stored header, byte-swapped
  // nonce, then the fixed padding block for a 640-bit message.
  always_comb begin
    word_d = '0;
    if (addr_q < 5'd19) begin
      word_d = words_q[addr_q];
    end else begin
      case (addr_q)
        5'd19:   word_d = {nonce_q[7:0], nonce_q[15:8], nonce_q[23:16], nonce_q[31:24]};
        5'd20:   word_d = 32'h8000_0000;
        5'd31:   word_d = 32'h0000_0280;
        default: word_d = '0;
      endcase
    end
  end

  // Load / serve FSM with request edge capture and the nonce counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_LOAD;
      cnt_q     <= '0;
      nonce_q   <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      pending_q <= 1'b0;
      d_req_q   <= 1'b0;
      rdy_q     <= 1'b0;
      full_q    <= 1'b0;
      wrap_q    <= 1'b0;
      for (int i = 0; i < 19; i++) words_q[i] <= '0;
    end else begin
      d_req_q <= req_i;
      rdy_q   <= 1'b0;
      wrap_q  <= 1'b0;
      if (clear_i) begin
        state_q   <= S_LOAD;
        cnt_q     <= '0;
        pending_q <= 1'b0;
        full_q    <= 1'b0;
      end else begin
        case (state_q)
          S_LOAD: begin
            if (load_en_i) begin
              // Bytes 76..79 are the nonce, little-endian as on the wire.
              if (cnt_q[6:2] == 5'd19) begin
                case (cnt_q[1:0])
                  2'd0:    nonce_q[7:0]   <= load_data_i;
                  2'd1:    nonce_q[15:8]  <= load_data_i;
                  2'd2:    nonce_q[23:16] <= load_data_i;
                  default: nonce_q[31:24] <= load_data_i;
                endcase
              end else begin
                case (cnt_q[1:0])
                  2'd0:    words_q[cnt_q[6:2]][31:24] <= load_data_i;
                  2'd1:    words_q[cnt_q[6:2]][23:16] <= load_data_i;
                  2'd2:    words_q[cnt_q[6:2]][15:8]  <= load_data_i;
                  default: words_q[cnt_q[6:2]][7:0]   <= load_data_i;
                endcase
              end
              cnt_q <= cnt_q + 7'd1;
              if (cnt_q == 7'd79) begin
                state_q <= S_FULL;
                full_q  <= 1'b1;
              end
            end
          end
          S_FULL: begin
            if (pending_q) begin
              data_q    <= word_d;
              pending_q <= 1'b0;
              rdy_q     <= 1'b1;
              state_q   <= S_SERVE;
            end
          end
          S_SERVE: state_q <= S_FULL;
          default: state_q <= S_LOAD;
        endcase
        // A new edge overrides the pending clear of a same-cycle serve.
        if (req_i && !d_req_q) begin
          pending_q <= 1'b1;
          addr_q    <= addr_i;
        end
        // Counting is frozen while the header (and its nonce bytes) loads.
        if (nonce_inc_i && state_q != S_LOAD) begin
          nonce_q <= nonce_q + 32'd1;
          wrap_q  <= &nonce_q;
        end
      end
    end
  end

  assign data_o  = data_q;
  assign rdy_o   = rdy_q;
  assign full_o  = full_q;
  assign nonce_o = nonce_q;
  assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_header_feeder.sv
// Bench for header_feeder: constant vector table, hand-written corner
// sequences and randomized headers checked against a byte-array model.
module tb_header_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_en;
  logic [7:0]  load_data;
  logic        clear;
  logic        nonce_inc;
  logic        req;
  logic [4:0]  addr;
  logic [31:0] data;
  logic        rdy;
  logic        full;
  logic [31:0] nonce;
  logic        wrap;

  header_feeder dut (
    .clk_i(clk), .rst_n_i(rst_n), .load_en_i(load_en), .load_data_i(load_data),
    .clear_i(clear), .nonce_inc_i(nonce_inc), .req_i(req), .addr_i(addr),
    .data_o(data), .rdy_o(rdy), .full_o(full), .nonce_o(nonce), .wrap_o(wrap)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // model: header bytes as loaded, nonce value, load count
  logic [7:0]  hdr [80];
  logic [31:0] m_nonce;
  int          mcnt;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input int a);
    if (a < 19) return {hdr[4*a], hdr[4*a+1], hdr[4*a+2], hdr[4*a+3]};
    if (a == 19) return {m_nonce[7:0], m_nonce[15:8], m_nonce[23:16], m_nonce[31:24]};
    if (a == 20) return 32'h8000_0000;
    if (a == 31) return 32'h0000_0280;
    return 32'h0;
  endfunction

  task automatic load_byte(input logic [7:0] b, input logic inc);
    load_en = 1'b1; load_data = b; nonce_inc = inc;
    tick();
    load_en = 1'b0; nonce_inc = 1'b0;
    hdr[mcnt] = b;
    if (mcnt >= 76) m_nonce[(mcnt-76)*8 +: 8] = b;
    mcnt++;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    mcnt = 0;
  endtask

  // Request a word; check latency, data, single pulse under held req, hold.
  task automatic do_req(input logic [4:0] a, input logic [31:0] exp, input string name);
    int lat = 0;
    bit seen = 0;
    int extra = 0;
    req = 1'b1; addr = a;
    while (!seen && lat < 10) begin
      tick();
      lat++;
      if (rdy) seen = 1;
    end
    chk({name, "_lat"}, lat, 2);
    chk({name, "_data"}, data, exp);
    repeat (3) begin
      tick();
      if (rdy) extra++;
    end
    req = 1'b0;
    tick();
    chk({name, "_pulses"}, extra, 0);
    chk({name, "_hold"}, data, exp);
  endtask

  initial begin
    vec_t vecs[8];
    vecs[0] = '{5'd0,  32'h0001_0203};
    vecs[1] = '{5'd1,  32'h0405_0607};
    vecs[2] = '{5'd18, 32'h4849_4A4B};
    vecs[3] = '{5'd19, 32'h4C4D_4E4F};
    vecs[4] = '{5'd20, 32'h8000_0000};
    vecs[5] = '{5'd25, 32'h0000_0000};
    vecs[6] = '{5'd30, 32'h0000_0000};
    vecs[7] = '{5'd31, 32'h0000_0280};

    rst_n = 1'b0; load_en = 0; load_data = 0; clear = 0; nonce_inc = 0; req = 0; addr = 0;
    m_nonce = 0; mcnt = 0;
    #12;
    chk("rst_data", data, 0);
    chk("rst_rdy", rdy, 0);
    chk("rst_full", full, 0);
    chk("rst_nonce", nonce, 0);
    chk("rst_wrap", wrap, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    tick();

    // header 0x00..0x4F
    for (int i = 0; i < 79; i++) load_byte(8'(i), 1'b0);
    chk("full_at79", full, 0);
    load_byte(8'h4F, 1'b0);
    chk("full_at80", full, 1);
    chk("nonce_loaded", nonce, 32'h4F4E_4D4C);
    for (int i = 0; i < 8; i++) do_req(vecs[i].a, vecs[i].exp, $sformatf("vec%0d", i));

    // edge during S_SERVE is kept and served next
    req = 1'b1; addr = 5'd2;
    tick();
    req = 1'b0;
    tick();
    chk("srv1_rdy", rdy, 1);
    chk("srv1_data", data, 32'h0809_0A0B);
    req = 1'b1; addr = 5'd5;
    tick();
    chk("srv2_rdy_gap", rdy, 0);
    tick();
    chk("srv2_rdy", rdy, 1);
    chk("srv2_data", data, 32'h1415_1617);
    req = 1'b0;
    tick();
    chk("srv2_rdy_end", rdy, 0);

    // nonce_inc in the serve cycle of word 19
    do_clear();
    for (int i = 0; i < 76; i++) load_byte(8'(i), 1'b0);
    load_byte(8'h05, 1'b0); load_byte(8'h00, 1'b0); load_byte(8'h00, 1'b0); load_byte(8'h00, 1'b0);
    req = 1'b1; addr = 5'd19;
    tick();
    nonce_inc = 1'b1;
    tick();
    nonce_inc = 1'b0;
    chk("n5_rdy", rdy, 1);
    chk("n5_data", data, 32'h0500_0000);
    chk("n5_nonce", nonce, 32'd6);
    req = 1'b0;
    tick();
    m_nonce = 32'd6;
    do_req(5'd19, 32'h0600_0000, "n6");

    // wrap; nonce_inc with the last byte is ignored
    do_clear();
    for (int i = 0; i < 76; i++) load_byte(8'(i + 3), 1'b0);
    for (int i = 0; i < 3; i++) load_byte(8'hFF, 1'b1);
    load_byte(8'hFF, 1'b1);
    chk("wrap_preload", nonce, 32'hFFFF_FFFF);
    chk("wrap_pre", wrap, 0);
    nonce_inc = 1'b1;
    tick();
    nonce_inc = 1'b0;
    m_nonce = 0;
    chk("wrap_nonce", nonce, 0);
    chk("wrap_pulse", wrap, 1);
    tick();
    chk("wrap_end", wrap, 0);
    do_req(5'd19, 32'h0, "wrap_w19");

    // request edge during load is served after full
    do_clear();
    for (int i = 0; i < 10; i++) load_byte(8'(i * 7), 1'b0);
    req = 1'b1; addr = 5'd3;
    begin
      int rdy_seen = 0;
      for (int i = 10; i < 80; i++) begin
        load_byte(8'(i * 7), 1'b0);
        if (rdy) rdy_seen++;
      end
      chk("pl_no_rdy", rdy_seen, 0);
    end
    chk("pl_full", full, 1);
    chk("pl_rdy0", rdy, 0);
    tick();
    chk("pl_rdy1", rdy, 1);
    chk("pl_data", data, exp_word(3));
    req = 1'b0;
    tick();

    // clear beats nonce_inc
    clear = 1'b1; nonce_inc = 1'b1;
    tick();
    clear = 1'b0; nonce_inc = 1'b0; mcnt = 0;
    chk("clr_nonce", nonce, m_nonce);
    chk("clr_full", full, 0);

    // clear mid-load then reload with 0xAA
    for (int i = 0; i < 40; i++) load_byte(8'(i), 1'b0);
    do_clear();
    for (int i = 0; i < 79; i++) load_byte(8'hAA, 1'b0);
    chk("aa_full79", full, 0);
    load_byte(8'hAA, 1'b0);
    chk("aa_full80", full, 1);
    do_req(5'd0, 32'hAAAA_AAAA, "aa_w0");

    // randomized headers and operations vs model
    for (int it = 0; it < 4; it++) begin
      do_clear();
      for (int i = 0; i < 80; i++) load_byte(8'($urandom), 1'($urandom));
      chk("rnd_full", full, 1);
      chk("rnd_nonce", nonce, m_nonce);
      for (int op = 0; op < 10; op++) begin
        if ($urandom_range(0, 1) == 0) begin
          logic [4:0] a;
          a = 5'($urandom_range(0, 31));
          do_req(a, exp_word(int'(a)), "rnd_req");
        end else begin
          logic exp_wrap;
          exp_wrap = (m_nonce == 32'hFFFF_FFFF);
          nonce_inc = 1'b1;
          tick();
          nonce_inc = 1'b0;
          m_nonce = m_nonce + 32'd1;
          chk("rnd_inc", nonce, m_nonce);
          chk("rnd_wrap", wrap, exp_wrap);
        end
      end
    end

    // async reset mid-serve
    req = 1'b1; addr = 5'd4;
    tick();
    tick();
    chk("ar_rdy_pre", rdy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_rdy", rdy, 0);
    chk("ar_data", data, 0);
    chk("ar_full", full, 0);
    chk("ar_nonce", nonce, 0);
    chk("ar_wrap", wrap, 0);
    req = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    tick();
    chk("ar_after_rdy", rdy, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
